// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU MEM stage has priority, host port is force-granted after STARVE_MAX denials.
// Define ARB_STATS_EN to enable the stat_host_gnt / stat_force saturating counters.
module dm_arbiter #(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stat_host_gnt,
    output logic [15:0]   stat_force
);

    typedef enum logic {
        NORM  = 1'b0,
        FORCE = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

    state_t        state_q;
    logic [3:0]    starve_cnt_q;
    logic          host_rvalid_q;
    logic [DW-1:0] host_rdata_q;
    logic          cpu_acc;
    logic          host_rd_gnt;

    assign cpu_acc     = cpu_rd | cpu_wr;
    assign host_rd_gnt = host_gnt & ~host_we;

    // Memory port mux; a simultaneous CPU read+write is treated as a write.
    always_comb begin
        cpu_stall = 1'b0;
        host_gnt  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == FORCE) begin
            cpu_stall = 1'b1;
            host_gnt  = host_req;
            mem_rd    = host_req & ~host_we;
            mem_wr    = host_req & host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_acc) begin
            mem_rd    = cpu_rd & ~cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_req) begin
            host_gnt  = 1'b1;
            mem_rd    = ~host_we;
            mem_wr    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NORM;
            starve_cnt_q  <= 4'd0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_rvalid_q <= host_rd_gnt;
            if (host_rd_gnt) begin
                host_rdata_q <= mem_rdata;
            end
            case (state_q)
                NORM: begin
                    // Only a denied host request advances the starvation count.
                    if (cpu_acc && host_req) begin
                        if (starve_cnt_q == CNT_LAST) begin
                            state_q      <= FORCE;
                            starve_cnt_q <= 4'd0;
                        end else begin
                            starve_cnt_q <= starve_cnt_q + 4'd1;
                        end
                    end else begin
                        starve_cnt_q <= 4'd0;
                    end
                end
                default: begin
                    state_q      <= NORM;
                    starve_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat_gnt_q;
    logic [15:0] stat_force_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_gnt_q   <= 16'h0;
            stat_force_q <= 16'h0;
        end else begin
            if (host_gnt && (stat_gnt_q != 16'hFFFF)) begin
                stat_gnt_q <= stat_gnt_q + 16'd1;
            end
            if ((state_q == FORCE) && (stat_force_q != 16'hFFFF)) begin
                stat_force_q <= stat_force_q + 16'd1;
            end
        end
    end

    assign stat_host_gnt = stat_gnt_q;
    assign stat_force    = stat_force_q;
`else
    assign stat_host_gnt = 16'h0;
    assign stat_force    = 16'h0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter (STARVE_MAX=4) with a small behavioural data memory.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr;
    logic [6:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [6:0]  host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        host_gnt, host_rvalid;
    logic        mem_rd, mem_wr;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] stat_host_gnt, stat_force;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(7), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stat_host_gnt(stat_host_gnt), .stat_force(stat_force)
    );

    // Single-port data memory: combinational read, write on posedge.
    logic [31:0] dm [128];
    bit          dm_init_done;
    assign mem_rdata = dm[mem_addr];
    always @(posedge clk) begin
        if (!dm_init_done) begin
            for (int i = 0; i < 128; i++) dm[i] <= 32'h0;
            dm[16] <= 32'h12345678;
            dm_init_done <= 1'b1;
        end else if (mem_wr) begin
            dm[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic        rst, crd, cwr;
        logic [6:0]  caddr;
        logic [31:0] cwd;
        logic        hreq, hwe;
        logic [6:0]  haddr;
        logic [31:0] hwd;
        logic        stall, gnt, rvalid, mrd, mwr;
        logic [6:0]  maddr;
        logic [31:0] crdata, hrdata;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic crd, input logic cwr, input logic [6:0] ca,
                       input logic [31:0] cwd, input logic hreq, input logic hwe,
                       input logic [6:0] ha, input logic [31:0] hwd,
                       input logic stall, input logic gnt, input logic rv, input logic mrd,
                       input logic mwr, input logic [6:0] ma, input logic [31:0] crdata,
                       input logic [31:0] hrdata);
        vec_t v;
        v.rst = r; v.crd = crd; v.cwr = cwr; v.caddr = ca; v.cwd = cwd;
        v.hreq = hreq; v.hwe = hwe; v.haddr = ha; v.hwd = hwd;
        v.stall = stall; v.gnt = gnt; v.rvalid = rv; v.mrd = mrd; v.mwr = mwr;
        v.maddr = ma; v.crdata = crdata; v.hrdata = hrdata;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp_v);
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp_v);
        end
    endtask

    task automatic drive(input logic r, input logic crd, input logic cwr, input logic [6:0] ca,
                         input logic [31:0] cwd, input logic hreq, input logic hwe,
                         input logic [6:0] ha, input logic [31:0] hwd);
        rst = r; cpu_rd = crd; cpu_wr = cwr; cpu_addr = ca; cpu_wdata = cwd;
        host_req = hreq; host_we = hwe; host_addr = ha; host_wdata = hwd;
    endtask

    task automatic step(input logic r, input logic crd, input logic cwr, input logic [6:0] ca,
                        input logic [31:0] cwd, input logic hreq, input logic hwe,
                        input logic [6:0] ha, input logic [31:0] hwd);
        @(posedge clk);
        #1;
        drive(r, crd, cwr, ca, cwd, hreq, hwe, ha, hwd);
        @(negedge clk);
    endtask

    logic [15:0] exp_sg, exp_sf;
    int          lat;
    bit          got_gnt;

    initial begin
        drive(1'b1, 0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);

        //   rst crd cwr caddr  cwdata        hreq hwe haddr  hwdata         stall gnt rv mrd mwr maddr  cpu_rdata      host_rdata
        add(1, 0, 0, 7'h00, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 0, 0, 0, 7'h00, 32'h0,        32'h0);
        add(1, 0, 0, 7'h00, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 0, 0, 0, 7'h00, 32'h0,        32'h0);
        add(0, 0, 0, 7'h00, 32'h0,        1, 1, 7'h05, 32'hDEADBEEF, 0, 1, 0, 0, 1, 7'h05, 32'h0,        32'h0);
        add(0, 1, 0, 7'h05, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 0, 1, 0, 7'h05, 32'hDEADBEEF, 32'h0);
        add(0, 0, 0, 7'h00, 32'h0,        1, 0, 7'h10, 32'h0,        0, 1, 0, 1, 0, 7'h10, 32'h12345678, 32'h0);
        add(0, 0, 0, 7'h00, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 1, 0, 0, 7'h00, 32'h0,        32'h12345678);
        add(0, 0, 0, 7'h00, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 0, 0, 0, 7'h00, 32'h0,        32'h12345678);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 7'h03, 32'h0,    1, 1, 7'h20, 32'hA5A5A5A5, 0, 0, 0, 1, 0, 7'h03, 32'h0,        32'h12345678);
        add(0, 1, 0, 7'h03, 32'h0,        1, 1, 7'h20, 32'hA5A5A5A5, 1, 1, 0, 0, 1, 7'h20, 32'h0,        32'h12345678);
        add(0, 1, 0, 7'h20, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 0, 1, 0, 7'h20, 32'hA5A5A5A5, 32'h12345678);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 7'h03, 32'h0,    1, 0, 7'h10, 32'h0,        0, 0, 0, 1, 0, 7'h03, 32'h0,        32'h12345678);
        // Reset asserted during the FORCE cycle: the granted read must be discarded.
        add(1, 1, 0, 7'h03, 32'h0,        1, 0, 7'h10, 32'h0,        1, 1, 0, 1, 0, 7'h10, 32'h12345678, 32'h12345678);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 7'h03, 32'h0,    1, 0, 7'h10, 32'h0,        0, 0, 0, 1, 0, 7'h03, 32'h0,        32'h0);
        add(0, 1, 0, 7'h03, 32'h0,        1, 0, 7'h10, 32'h0,        1, 1, 0, 1, 0, 7'h10, 32'h12345678, 32'h0);
        add(0, 0, 0, 7'h00, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 1, 0, 0, 7'h00, 32'h0,        32'h12345678);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 7'h03, 32'h0,    1, 1, 7'h30, 32'h1,        0, 0, 0, 1, 0, 7'h03, 32'h0,        32'h12345678);
        // Host drops its request in the FORCE cycle: slot wasted, CPU still stalled.
        add(0, 1, 0, 7'h03, 32'h0,        0, 1, 7'h30, 32'h1,        1, 0, 0, 0, 0, 7'h30, 32'h0,        32'h12345678);
        add(0, 1, 0, 7'h03, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 0, 1, 0, 7'h03, 32'h0,        32'h12345678);
        add(0, 1, 1, 7'h40, 32'h55,       0, 0, 7'h00, 32'h0,        0, 0, 0, 0, 1, 7'h40, 32'h0,        32'h12345678);
        add(0, 1, 0, 7'h40, 32'h0,        0, 0, 7'h00, 32'h0,        0, 0, 0, 1, 0, 7'h40, 32'h55,       32'h12345678);
        add(0, 0, 0, 7'h00, 32'h0,        1, 1, 7'h41, 32'h7,        0, 1, 0, 0, 1, 7'h41, 32'h0,        32'h12345678);
        add(0, 0, 0, 7'h00, 32'h0,        1, 1, 7'h41, 32'h7,        0, 1, 0, 0, 1, 7'h41, 32'h7,        32'h12345678);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].crd, vq[i].cwr, vq[i].caddr, vq[i].cwd,
                 vq[i].hreq, vq[i].hwe, vq[i].haddr, vq[i].hwd);
            n_vec++;
            check("cpu_stall",   i, 32'(cpu_stall),   32'(vq[i].stall));
            check("host_gnt",    i, 32'(host_gnt),    32'(vq[i].gnt));
            check("host_rvalid", i, 32'(host_rvalid), 32'(vq[i].rvalid));
            check("mem_rd",      i, 32'(mem_rd),      32'(vq[i].mrd));
            check("mem_wr",      i, 32'(mem_wr),      32'(vq[i].mwr));
            check("mem_addr",    i, 32'(mem_addr),    32'(vq[i].maddr));
            check("cpu_rdata",   i, cpu_rdata,        vq[i].crdata);
            check("host_rdata",  i, host_rdata,       vq[i].hrdata);
        end

        // Hand sequence: reset, host write, starved host write, host read; then statistics.
        step(1, 0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0);
        step(1, 0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0);
        n_vec++;
        check("stat_reset_gnt",   100, 32'(stat_host_gnt), 32'h0);
        check("stat_reset_force", 100, 32'(stat_force),    32'h0);
        step(0, 0, 0, 7'h00, 32'h0, 1, 1, 7'h05, 32'hDEADBEEF);
        n_vec++;
        check("seq_host_wr_gnt", 101, 32'(host_gnt), 32'h1);

        @(posedge clk);
        #1;
        drive(0, 1, 0, 7'h03, 32'h0, 1, 1, 7'h22, 32'h0BADF00D);
        got_gnt = 1'b0;
        lat = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (host_gnt) begin
                got_gnt = 1'b1;
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        check("seq_gnt_seen",    102, 32'(got_gnt),   32'h1);
        check("seq_gnt_latency", 102, 32'(lat),       32'd4);
        check("seq_force_stall", 102, 32'(cpu_stall), 32'h1);
        step(0, 1, 0, 7'h22, 32'h0, 0, 0, 7'h00, 32'h0);
        n_vec++;
        check("seq_post_stall", 103, 32'(cpu_stall), 32'h0);
        check("seq_post_rdata", 103, cpu_rdata,      32'h0BADF00D);

        step(0, 0, 0, 7'h00, 32'h0, 1, 0, 7'h10, 32'h0);
        n_vec++;
        check("seq_host_rd_gnt", 104, 32'(host_gnt), 32'h1);
        step(0, 0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0);
        n_vec++;
        check("seq_rvalid", 105, 32'(host_rvalid), 32'h1);
        check("seq_rdata",  105, host_rdata,       32'h12345678);
        step(0, 0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0);
        n_vec++;
        check("seq_rvalid_drop", 106, 32'(host_rvalid), 32'h0);
        check("seq_rdata_hold",  106, host_rdata,       32'h12345678);

`ifdef ARB_STATS_EN
        exp_sg = 16'd3;
        exp_sf = 16'd1;
`else
        exp_sg = 16'd0;
        exp_sf = 16'd0;
`endif
        n_vec++;
        check("stat_host_gnt", 107, 32'(stat_host_gnt), 32'(exp_sg));
        check("stat_force",    107, 32'(stat_force),    32'(exp_sf));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
